wave_rom_scheduler: RTL and testbench
=====================================

Name: wave_rom_scheduler

Overview:
- Time-multiplexes one shared 1024x8 waveform ROM between NUM_CH independent generator channels.
- The ROM holds four 256-entry tables selected by rom_addr[9:8]: 0 sine, 1 square, 2 sawtooth, 3 triangular.
- The block owns per-channel phase accumulators, wave-select and step registers, and a round-robin slot scheduler.
- Returned ROM data is tagged back to its channel, and the block produces a mixed sample once per frame for the DAC path.

Parameters:
- NUM_CH, 2: number of channels; range 1..8.
- PHASE_W, 16: phase accumulator width; the top 8 bits form the table index; minimum 8.
- ROM_LAT, 1: ROM read latency in cycles; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable for the slot scheduler.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  3  target channel of the configuration write.
- cfg_wave  in  2  wave select to write.
- cfg_step  in  PHASE_W  phase increment to write.
- rom_rden  out  1  ROM read enable.
- rom_addr  out  10  ROM address: {wave, phase[PHASE_W-1 -: 8]}.
- rom_q  in  8  ROM data, valid ROM_LAT cycles after rom_rden is sampled high.
- ch_data  out  NUM_CH*8  latest sample per channel; channel k occupies bits [8k+7:8k].
- ch_valid  out  NUM_CH  1-cycle pulse when ch_data for channel k updates.
- mix_out  out  8+clog2(NUM_CH) (min 9)  sum of all ch_data, unsigned; the minimum of 9 bits applies when NUM_CH is 1.
- sample_tick  out  1  1-cycle pulse when mix_out updates.

Behaviour:
- Reset: rom_rden=0, rom_addr=0, ch_data=0, ch_valid=0, mix_out=0, sample_tick=0, slot=0.
- Reset also clears every phase, step, wave and shadow register to 0, and flushes the tag pipeline. Reset mid-frame discards in-flight reads with no capture.
- Slot counter:
  - Advances 0..NUM_CH-1 and wraps on every clk with en=1; it holds while en=0.
  - A frame is one pass through the slots 0..NUM_CH-1.
- Issue, on a cycle with en=1 and slot=s:
  - Registers rom_rden=1 and rom_addr={wave[s], phase[s][PHASE_W-1 -: 8]}.
  - Updates phase[s] <= phase[s]+step[s], modulo 2^PHASE_W (silent wrap).
  - Pushes {valid=1, ch=s} into the ROM_LAT-deep tag pipeline.
- Issue, on a cycle with en=0: registers rom_rden=0 and pushes a bubble into the tag pipeline. rom_addr holds its value.
- Capture:
  - When the tag at the pipeline head is valid with ch=s, ch_data[s] <= rom_q and ch_valid[s] pulses for one cycle.
  - rom_q is captured on the edge at which the ROM has held the data for ROM_LAT edges since rom_rden was registered.
  - Capture latency from the issue edge to the ch_data update is ROM_LAT+1 cycles.
- Mix:
  - The cycle after the capture of the channel NUM_CH-1 sample, mix_out <= zero-extended sum of all ch_data, and sample_tick pulses.
  - The sum cannot overflow the mix_out width.
- Dropping en:
  - In-flight reads still drain and capture.
  - Mixing still occurs if the channel NUM_CH-1 capture drains.
  - On resume, the scheduler continues from the held slot.
- Configuration:
  - cfg_we writes the shadow registers shadow_wave[cfg_ch] and shadow_step[cfg_ch].
  - Shadow values commit to the active wave/step registers on the issue cycle of slot 0, so each frame uses one consistent configuration.
  - A write landing on the slot-0 issue cycle is not committed that frame; it is used from the next frame.
  - Writes with cfg_ch >= NUM_CH are ignored.
  - Writes are accepted regardless of en.
  - Back-to-back writes to the same channel: the last one wins.
- step=0: the channel holds its phase and repeats the same table entry.
- Throughput: one ROM access per cycle while en=1. Sample rate = f_clk / NUM_CH per channel.

Optional Feature:
- Macro: WAVE_PHASE_SYNC_EN.
- When defined:
  - Adds input phase_sync (1 bit).
  - A high pulse is latched. At the next slot-0 issue cycle, all phase accumulators load 0 before address formation, so every channel reads index 0 in that frame.
  - The latch then clears.
  - phase_sync and a slot-0 issue in the same cycle take effect in that same frame.
- When undefined: the port is absent, and phases only ever advance by step.

Test Plan:
1. Reset with en=1 → rom_rden=0, all outputs 0; after releasing rst, the first rom_rden=1 has rom_addr=0x000, and ch_data[0] updates 2 cycles later (ROM_LAT=1).
2. NUM_CH=2: ch0 wave=0, step=0x0100; ch1 wave=2, step=0x0200; en=1 → rom_addr sequence 0x000, 0x200, 0x001, 0x202, 0x002, 0x204...; sample_tick every 2 cycles after fill.
3. ch0 step=0x8000, 5 frames → index sequence 0x00, 0x80, 0x00, 0x80, 0x00 (wrap verified).
4. cfg write of ch1 wave=3 on the slot-0 issue cycle → the current frame still reads table 2; the next frame's ch1 rom_addr[9:8]=3.
5. Drop en for 3 cycles mid-frame → no rom_rden, the in-flight capture still completes, phases unchanged; resume continues from the held slot.
6. With WAVE_PHASE_SYNC_EN: pulse phase_sync mid-frame → the next frame issues index 0x00 for both channels. Also: ROM model returns 0xFF for both channels → mix_out=0x1FE.

Source files
------------

// File: rtl/wave_rom_scheduler.sv
// ---------------------------------------------------------------------------
// wave_rom_scheduler
//
// Shares one 1024x8 waveform ROM between NUM_CH generator channels using a
// round-robin slot scheduler. The ROM holds four 256-entry tables selected by
// rom_addr[9:8] (0 sine, 1 square, 2 sawtooth, 3 triangular). Each channel
// owns a phase accumulator plus wave/step registers. Configuration is written
// into shadow registers and committed at the start of every frame, so all
// reads in one frame use one consistent configuration. Returned ROM data is
// steered back to its channel by a tag pipeline. Once per frame, after the
// last channel's sample lands, the unsigned sum of all channel samples is
// presented on mix_out.
//
// Optional feature (macro WAVE_PHASE_SYNC_EN):
//   Adds input phase_sync. A pulse is latched, and at the next slot-0 issue
//   every phase accumulator is cleared before the address is formed.
//
// Parameters:
//   NUM_CH  - number of channels, 1..8
//   PHASE_W - phase accumulator width (>= 8); the top 8 bits index the table
//   ROM_LAT - ROM read latency in cycles, 1 or 2
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   en            - run enable for the slot scheduler
//   cfg_we        - configuration write strobe
//   cfg_ch        - target channel (writes to cfg_ch >= NUM_CH are ignored)
//   cfg_wave      - wave select written to the shadow register
//   cfg_step      - phase increment written to the shadow register
//   phase_sync    - (WAVE_PHASE_SYNC_EN only) phase realignment request
//   rom_rden      - ROM read enable (registered)
//   rom_addr      - ROM address {wave, phase[PHASE_W-1 -: 8]} (registered)
//   rom_q         - ROM data, valid ROM_LAT cycles after rom_rden is sampled
//   ch_data       - latest sample per channel, channel k in [8k+7:8k]
//   ch_valid      - per-channel 1-cycle pulse when ch_data updates
//   mix_out       - unsigned sum of all ch_data
//   sample_tick   - 1-cycle pulse when mix_out updates
// ---------------------------------------------------------------------------
module wave_rom_scheduler #(
  parameter  int NUM_CH  = 2,
  parameter  int PHASE_W = 16,
  parameter  int ROM_LAT = 1,
  localparam int SLOT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W   = 8 + SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [1:0]          cfg_wave,
  input  logic [PHASE_W-1:0]  cfg_step,
`ifdef WAVE_PHASE_SYNC_EN
  input  logic                phase_sync,
`endif
  output logic                rom_rden,
  output logic [9:0]          rom_addr,
  input  logic [7:0]          rom_q,
  output logic [NUM_CH*8-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_valid,
  output logic [MIX_W-1:0]    mix_out,
  output logic                sample_tick
);

  // Elaboration-time parameter range checks.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("wave_rom_scheduler: NUM_CH must be in 1..8");
  end
  if (PHASE_W < 8) begin : g_bad_phase_w
    $error("wave_rom_scheduler: PHASE_W must be at least 8");
  end
  if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_bad_rom_lat
    $error("wave_rom_scheduler: ROM_LAT must be 1 or 2");
  end

  // Tag travelling alongside each ROM read so the data can be steered back.
  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] ch;
  } tag_t;

  // Stage 0 is registered together with rom_rden/rom_addr; the remaining
  // ROM_LAT stages cover the ROM latency, giving ROM_LAT+1 cycles from the
  // issue edge to the capture edge.
  localparam int TAG_DEPTH = ROM_LAT + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SLOT_W-1:0]  slot_q,        slot_d;
  logic [PHASE_W-1:0] phase_q        [NUM_CH];
  logic [PHASE_W-1:0] phase_d        [NUM_CH];
  logic [PHASE_W-1:0] step_q         [NUM_CH];
  logic [PHASE_W-1:0] step_d         [NUM_CH];
  logic [1:0]         wave_q         [NUM_CH];
  logic [1:0]         wave_d         [NUM_CH];
  logic [PHASE_W-1:0] shadow_step_q  [NUM_CH];
  logic [PHASE_W-1:0] shadow_step_d  [NUM_CH];
  logic [1:0]         shadow_wave_q  [NUM_CH];
  logic [1:0]         shadow_wave_d  [NUM_CH];
  logic               rom_rden_q,    rom_rden_d;
  logic [9:0]         rom_addr_q,    rom_addr_d;
  tag_t               tag_q          [TAG_DEPTH];
  tag_t               tag_d          [TAG_DEPTH];
  logic [7:0]         ch_data_q      [NUM_CH];
  logic [7:0]         ch_data_d      [NUM_CH];
  logic [NUM_CH-1:0]  ch_valid_q,    ch_valid_d;
  logic [MIX_W-1:0]   mix_q,         mix_d;
  logic               sample_tick_q, sample_tick_d;
`ifdef WAVE_PHASE_SYNC_EN
  logic               sync_pend_q,   sync_pend_d;
`endif

  logic               frame_start;
  logic [MIX_W-1:0]   mix_sum;
  tag_t               head;

  assign head = tag_q[TAG_DEPTH-1];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d is given a default before any conditional assignment,
    // so no path leaves a variable unassigned and no latch is inferred.
    slot_d        = slot_q;
    phase_d       = phase_q;
    step_d        = step_q;
    wave_d        = wave_q;
    shadow_step_d = shadow_step_q;
    shadow_wave_d = shadow_wave_q;
    rom_rden_d    = en;
    rom_addr_d    = rom_addr_q;
    tag_d[0]      = '0;
    for (int i = 1; i < TAG_DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    ch_data_d     = ch_data_q;
    ch_valid_d    = '0;
    mix_d         = mix_q;
    sample_tick_d = ch_valid_q[NUM_CH-1];
    mix_sum       = '0;
    frame_start   = en && (slot_q == '0);
`ifdef WAVE_PHASE_SYNC_EN
    sync_pend_d   = sync_pend_q | phase_sync;
`endif

    // Configuration writes land in the shadow registers only.
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_we && (cfg_ch == 3'(k))) begin
        shadow_wave_d[k] = cfg_wave;
        shadow_step_d[k] = cfg_step;
      end
    end

    // Frame start: commit the shadow configuration as it stood before this
    // edge. The slot-0 read below already uses the committed values so the
    // whole frame sees one configuration; a write arriving on this same
    // cycle only reaches the shadow and waits for the next frame.
    if (frame_start) begin
      wave_d = shadow_wave_q;
      step_d = shadow_step_q;
`ifdef WAVE_PHASE_SYNC_EN
      if (sync_pend_q || phase_sync) begin
        for (int k = 0; k < NUM_CH; k++) begin
          phase_d[k] = '0;
        end
        sync_pend_d = 1'b0;
      end
`endif
    end

    // Issue: form the address from the pre-increment phase, then advance it.
    if (en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot_q == SLOT_W'(k)) begin
          rom_addr_d = {wave_d[k], phase_d[k][PHASE_W-1 -: 8]};
          phase_d[k] = phase_d[k] + step_d[k];
        end
      end
      tag_d[0].valid = 1'b1;
      tag_d[0].ch    = slot_q;
      slot_d = (slot_q == SLOT_W'(NUM_CH-1)) ? '0 : slot_q + 1'b1;
    end

    // Capture: the head tag lines up with the data currently on rom_q.
    if (head.valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (head.ch == SLOT_W'(k)) begin
          ch_data_d[k]  = rom_q;
          ch_valid_d[k] = 1'b1;
        end
      end
    end

    // Mix one cycle after the last channel's capture, when ch_data_q already
    // holds the new sample. MIX_W is wide enough that the sum never wraps.
    for (int k = 0; k < NUM_CH; k++) begin
      mix_sum = mix_sum + MIX_W'(ch_data_q[k]);
    end
    if (ch_valid_q[NUM_CH-1]) begin
      mix_d = mix_sum;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      rom_rden_q    <= 1'b0;
      rom_addr_q    <= '0;
      ch_valid_q    <= '0;
      mix_q         <= '0;
      sample_tick_q <= 1'b0;
`ifdef WAVE_PHASE_SYNC_EN
      sync_pend_q   <= 1'b0;
`endif
      // NOTE: these per-channel arrays are small flop banks, not RAM, so they
      // are reset element by element; flushing the tags drops in-flight reads.
      for (int k = 0; k < NUM_CH; k++) begin
        phase_q[k]       <= '0;
        step_q[k]        <= '0;
        wave_q[k]        <= '0;
        shadow_step_q[k] <= '0;
        shadow_wave_q[k] <= '0;
        ch_data_q[k]     <= '0;
      end
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      slot_q        <= slot_d;
      phase_q       <= phase_d;
      step_q        <= step_d;
      wave_q        <= wave_d;
      shadow_step_q <= shadow_step_d;
      shadow_wave_q <= shadow_wave_d;
      rom_rden_q    <= rom_rden_d;
      rom_addr_q    <= rom_addr_d;
      tag_q         <= tag_d;
      ch_data_q     <= ch_data_d;
      ch_valid_q    <= ch_valid_d;
      mix_q         <= mix_d;
      sample_tick_q <= sample_tick_d;
`ifdef WAVE_PHASE_SYNC_EN
      sync_pend_q   <= sync_pend_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rom_rden    = rom_rden_q;
  assign rom_addr    = rom_addr_q;
  assign ch_valid    = ch_valid_q;
  assign mix_out     = mix_q;
  assign sample_tick = sample_tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_data
    assign ch_data[8*g +: 8] = ch_data_q[g];
  end

endmodule

// File: tb/tb_wave_rom_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wave_rom_scheduler
//
// Directed bench for wave_rom_scheduler with NUM_CH=2, PHASE_W=16, ROM_LAT=1.
// The ROM model returns addr[7:0] ^ {addr[9:8], 6'b0} (or 0xFF when
// rom_all_ff is set), registered one cycle after rom_rden is sampled.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wave_rom_scheduler;

  localparam int NUM_CH  = 2;
  localparam int PHASE_W = 16;
  localparam int ROM_LAT = 1;
  localparam int MIX_W   = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                cfg_we;
  logic [2:0]          cfg_ch;
  logic [1:0]          cfg_wave;
  logic [PHASE_W-1:0]  cfg_step;
`ifdef WAVE_PHASE_SYNC_EN
  logic                phase_sync;
`endif
  logic                rom_rden;
  logic [9:0]          rom_addr;
  logic [7:0]          rom_q;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid;
  logic [MIX_W-1:0]    mix_out;
  logic                sample_tick;

  logic                rom_all_ff;
  logic [7:0]          rom_pipe [ROM_LAT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wave_rom_scheduler #(
    .NUM_CH (NUM_CH),
    .PHASE_W(PHASE_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_wave   (cfg_wave),
    .cfg_step   (cfg_step),
`ifdef WAVE_PHASE_SYNC_EN
    .phase_sync (phase_sync),
`endif
    .rom_rden   (rom_rden),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .mix_out    (mix_out),
    .sample_tick(sample_tick)
  );

  // ROM model.
  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    if (rom_all_ff) return 8'hFF;
    return a[7:0] ^ {a[9:8], 6'b0};
  endfunction

  always @(posedge clk) begin
    if (rom_rden) rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] wave,
                           input logic [PHASE_W-1:0] step);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_wave = wave;
    cfg_step = step;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Expected values after each edge of the steady-state run in test 2.
  logic [9:0]       t2_addr  [8] = '{10'h000, 10'h200, 10'h001, 10'h202,
                                     10'h002, 10'h204, 10'h003, 10'h206};
  logic [1:0]       t2_valid [8] = '{2'b00, 2'b00, 2'b01, 2'b10,
                                     2'b01, 2'b10, 2'b01, 2'b10};
  logic             t2_tick  [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b1, 1'b0};
  logic [MIX_W-1:0] t2_mix   [8] = '{9'h000, 9'h000, 9'h000, 9'h000,
                                     9'h080, 9'h080, 9'h083, 9'h083};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [9:0] exp_addr;
    rst        = 1'b1;
    en         = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_wave   = '0;
    cfg_step   = '0;
    rom_all_ff = 1'b0;
`ifdef WAVE_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
    repeat (3) tick();

    // Reset state with en held high.
    check("rst_rden",  32'(rom_rden),    0);
    check("rst_addr",  32'(rom_addr),    0);
    check("rst_data",  32'(ch_data),     0);
    check("rst_valid", 32'(ch_valid),    0);
    check("rst_mix",   32'(mix_out),     0);
    check("rst_tick",  32'(sample_tick), 0);

    // Test 1: first issue after reset release, capture two cycles later.
    rst = 1'b0;
    tick();
    check("t1_rden", 32'(rom_rden), 1);
    check("t1_addr", 32'(rom_addr), 32'h000);
    tick();
    check("t1_valid_e1", 32'(ch_valid), 0);
    tick();
    check("t1_valid_e2", 32'(ch_valid), 32'b01);

    // Test 2: two channels, round-robin addresses, mix every frame.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    cfg_write(3'd0, 2'd0, 16'h0100);
    cfg_write(3'd1, 2'd2, 16'h0200);
    cfg_write(3'd5, 2'd3, 16'h7777);   // out of range, must be ignored
    check("t2_idle_rden", 32'(rom_rden), 0);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t2_addr_%0d",  k), 32'(rom_addr),    32'(t2_addr[k]));
      check($sformatf("t2_valid_%0d", k), 32'(ch_valid),    32'(t2_valid[k]));
      check($sformatf("t2_tick_%0d",  k), 32'(sample_tick), 32'(t2_tick[k]));
      check($sformatf("t2_mix_%0d",   k), 32'(mix_out),     32'(t2_mix[k]));
    end

    // Test 4: write ch1 wave=3 on the slot-0 issue cycle.
    cfg_we   = 1'b1;
    cfg_ch   = 3'd1;
    cfg_wave = 2'd3;
    cfg_step = 16'h0200;
    tick();
    cfg_we = 1'b0;
    check("t4_addr_s0",  32'(rom_addr), 32'h004);
    tick();
    check("t4_addr_old", 32'(rom_addr), 32'h208);
    tick();
    check("t4_addr_s0b", 32'(rom_addr), 32'h005);
    tick();
    check("t4_addr_new", 32'(rom_addr), 32'h30A);

    // Test 5: drop en for 3 cycles mid-frame.
    tick();
    check("t5_addr_pre", 32'(rom_addr), 32'h006);
    en = 1'b0;
    tick();
    check("t5_rden_g1",  32'(rom_rden), 0);
    check("t5_addr_g1",  32'(rom_addr), 32'h006);
    check("t5_valid_g1", 32'(ch_valid), 32'b10);
    check("t5_ch1_g1",   32'(ch_data[15:8]), 32'hCA);
    tick();
    check("t5_valid_g2", 32'(ch_valid), 32'b01);
    check("t5_ch0_g2",   32'(ch_data[7:0]), 32'h06);
    check("t5_tick_g2",  32'(sample_tick), 1);
    check("t5_mix_g2",   32'(mix_out), 32'h0CF);
    tick();
    check("t5_rden_g3",  32'(rom_rden), 0);
    check("t5_valid_g3", 32'(ch_valid), 0);
    en = 1'b1;
    tick();
    check("t5_resume_rden", 32'(rom_rden), 1);
    check("t5_resume_ch1",  32'(rom_addr), 32'h30C);
    tick();
    check("t5_resume_ch0",  32'(rom_addr), 32'h007);

    // Full-scale samples on both channels.
    rom_all_ff = 1'b1;
    repeat (8) tick();
    check("t6_mix_max",  32'(mix_out), 32'h1FE);
    check("t6_data_max", 32'(ch_data), 32'hFFFF);
    rom_all_ff = 1'b0;

    // Test 3: step=0x8000 wraps the phase every other frame.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    cfg_write(3'd0, 2'd0, 16'h8000);
    cfg_write(3'd1, 2'd1, 16'h0100);
    cfg_write(3'd1, 2'd1, 16'h0100);   // back-to-back, same value
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k % 2 == 0) exp_addr = ((k / 2) % 2 != 0) ? 10'h080 : 10'h000;
      else            exp_addr = 10'h100 + 10'(k / 2);
      check($sformatf("t3_addr_%0d", k), 32'(rom_addr), 32'(exp_addr));
    end

`ifdef WAVE_PHASE_SYNC_EN
    // Phase sync pulsed mid-frame realigns both channels next frame.
    tick();
    check("ps_addr_s0", 32'(rom_addr), 32'h080);
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    check("ps_addr_s1", 32'(rom_addr), 32'h105);
    tick();
    check("ps_addr_s2", 32'(rom_addr), 32'h000);
    tick();
    check("ps_addr_s3", 32'(rom_addr), 32'h100);
    tick();
    check("ps_addr_s4", 32'(rom_addr), 32'h080);
    tick();
    check("ps_addr_s5", 32'(rom_addr), 32'h101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
